// File: rtl/uart_rx_framer.sv
// uart_rx_framer: hunts for SYNC_WORD in the UART receive word stream, then
// collects a length-prefixed, checksummed frame into a local buffer. Frames
// that pass the checksum are released on a valid/ready stream with m_last.
// Frames with a bad length, a bad checksum or an inter-word stall are dropped
// with a one-cycle frame_err pulse.
module uart_rx_framer #(
  parameter int unsigned       W_OUT        = 16,
  parameter logic [W_OUT-1:0]  SYNC_WORD    = 16'hA55A,
  parameter int unsigned       MAX_LEN      = 16,
  parameter int unsigned       TIMEOUT_CLKS = 2000000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_valid,
  input  logic [W_OUT-1:0] s_data,
  output logic             m_valid,
  output logic [W_OUT-1:0] m_data,
  output logic             m_last,
  input  logic             m_ready,
  output logic             frame_err,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [2:0] HUNT    = 3'd0;
  localparam logic [2:0] LEN     = 3'd1;
  localparam logic [2:0] PAYLOAD = 3'd2;
  localparam logic [2:0] CSUM    = 3'd3;
  localparam logic [2:0] DRAIN   = 3'd4;

  localparam logic [TW-1:0]    TMO_LAST  = TW'(TIMEOUT_CLKS - 1);
  localparam logic [W_OUT-1:0] MAX_LEN_W = W_OUT'(MAX_LEN);

  logic [2:0]       state;
  logic [W_OUT-1:0] pay_buf [MAX_LEN];
  logic [IW-1:0]    len_m1;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;
  logic [W_OUT-1:0] sum;
  logic [TW-1:0]    tmo_cnt;
  logic             in_frame;
  logic             expire;
  logic             len_ok;

  // Frame-state decode, timeout expiry and length range check
  always_comb begin
    in_frame = (state == LEN) || (state == PAYLOAD) || (state == CSUM);
    // an arriving word always beats a coincident expiry
    expire   = in_frame && !s_valid && (tmo_cnt == TMO_LAST);
    len_ok   = (s_data != '0) && (s_data <= MAX_LEN_W);
  end

  // Output stream is decoded from registered state only, never from m_ready
  always_comb begin
    m_valid = (state == DRAIN);
    m_data  = m_valid ? pay_buf[rd_idx] : '0;
    m_last  = m_valid && (rd_idx == len_m1);
    busy    = (state != HUNT);
  end

  // Payload buffer write port; contents need no reset since reads are gated
  always_ff @(posedge clk) begin
    if (state == PAYLOAD && s_valid) begin
      pay_buf[wr_idx] <= s_data;
    end
  end

  // Framing state machine, checksum accumulation and inter-word timeout
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= HUNT;
      len_m1    <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      sum       <= '0;
      tmo_cnt   <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      tmo_cnt   <= '0;
      if (expire) begin
        frame_err <= 1'b1;
        state     <= HUNT;
      end else begin
        case (state)
          HUNT: begin
            if (s_valid && s_data == SYNC_WORD) begin
              state <= LEN;
            end
          end
          LEN: begin
            if (s_valid) begin
              if (len_ok) begin
                len_m1 <= IW'(s_data - W_OUT'(1));
                sum    <= '0;
                wr_idx <= '0;
                state  <= PAYLOAD;
              end else begin
                frame_err <= 1'b1;
                state     <= HUNT;
              end
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          PAYLOAD: begin
            if (s_valid) begin
              sum    <= sum + s_data;
              wr_idx <= wr_idx + 1'b1;
              if (wr_idx == len_m1) begin
                state <= CSUM;
              end
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          CSUM: begin
            if (s_valid) begin
              if (s_data == sum) begin
                rd_idx <= '0;
                state  <= DRAIN;
              end else begin
                frame_err <= 1'b1;
                state     <= HUNT;
              end
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          DRAIN: begin
            // words arriving while draining are dropped and flagged
            overflow <= s_valid;
            if (m_ready) begin
              if (rd_idx == len_m1) begin
                state <= HUNT;
              end else begin
                rd_idx <= rd_idx + 1'b1;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Testbench for uart_rx_framer: directed frames plus randomized attempts,
// checked against a frame-level parser of the word stream.
module tb_uart_rx_framer;

  localparam int unsigned TMO  = 50;
  localparam int unsigned MAXL = 16;
  localparam logic [15:0] SYNC = 16'hA55A;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        m_ready = 1'b0;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_last;
  logic        frame_err;
  logic        overflow;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned fe_cnt = 0;
  int unsigned ov_cnt = 0;
  int unsigned rdy_mode = 0;
  int unsigned rdy_phase = 0;

  // expected output words as {last, data}
  logic [16:0] exp_q[$];
  logic [16:0] pend_q[$];

  uart_rx_framer #(
    .W_OUT(16),
    .SYNC_WORD(SYNC),
    .MAX_LEN(MAXL),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .s_valid(s_valid),
    .s_data(s_data),
    .m_valid(m_valid),
    .m_data(m_data),
    .m_last(m_last),
    .m_ready(m_ready),
    .frame_err(frame_err),
    .overflow(overflow),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output monitor: pulse counting and in-order payload comparison
  always @(negedge clk) begin
    if (rstn) begin
      if (frame_err) fe_cnt++;
      if (overflow) ov_cnt++;
      check_eq("err_ovf_excl", 32'(frame_err & overflow), 0);
      if (exp_q.size() == 0) begin
        check_eq("m_valid_idle", 32'(m_valid), 0);
      end else if (m_valid) begin
        check_eq("m_data", 32'(m_data), 32'(exp_q[0][15:0]));
        check_eq("m_last", 32'(m_last), 32'(exp_q[0][16]));
        if (m_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Consumer ready: always, random, or the 1,0,0 pattern
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: m_ready = 1'b1;
        1: m_ready = 1'($urandom_range(0, 1));
        default: begin
          m_ready = (rdy_phase % 3 == 0);
          rdy_phase++;
        end
      endcase
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] w);
    s_valid = 1'b1;
    s_data  = w;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = 16'($urandom);
  endtask

  function automatic int unsigned gap_of(input int unsigned g[$], input int unsigned i);
    return (i < g.size()) ? g[i] : 0;
  endfunction

  // Frame-level parse of one attempt: g[i] idle clocks precede word i,
  // tail idle clocks follow the last word. Good payloads go to pend_q.
  task automatic model_attempt(input logic [15:0] w[$], input int unsigned g[$],
                               input int unsigned tail, output int unsigned errs);
    int unsigned i, n, len, cs, late;
    logic [15:0] s;
    n = w.size();
    errs = 0;
    i = 0;
    while (i < n) begin
      if (w[i] != SYNC) begin
        i++;
        continue;
      end
      if (i + 1 >= n) begin
        if (tail >= TMO) errs++;
        break;
      end
      if (gap_of(g, i + 1) >= TMO) begin
        errs++;
        i = i + 1;
        continue;
      end
      len = 32'(w[i + 1]);
      if (len == 0 || len > MAXL) begin
        errs++;
        i = i + 2;
        continue;
      end
      cs = i + 2 + len;
      late = 0;
      for (int unsigned k = i + 2; k <= cs && k < n; k++)
        if (late == 0 && gap_of(g, k) >= TMO) late = k;
      if (late != 0) begin
        errs++;
        i = late;
        continue;
      end
      if (cs >= n) begin
        if (tail >= TMO) errs++;
        break;
      end
      s = '0;
      for (int unsigned k = i + 2; k < cs; k++) s = s + w[k];
      if (w[cs] == s) begin
        for (int unsigned k = i + 2; k < cs; k++) pend_q.push_back({k == cs - 1, w[k]});
      end else begin
        errs++;
      end
      i = cs + 1;
    end
  endtask

  task automatic run_attempt(input logic [15:0] w[$], input int unsigned g[$],
                             input int unsigned tail, input bit inject, input logic [15:0] inj);
    int unsigned exp_err, fe0, ov0, cyc, n_out;
    bit good;
    pend_q.delete();
    model_attempt(w, g, tail, exp_err);
    n_out = pend_q.size();
    good  = (n_out != 0);
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    foreach (w[i]) begin
      idle(gap_of(g, i));
      send(w[i]);
    end
    if (good) begin
      exp_q = pend_q;
      pend_q.delete();
      check_eq("latency", 32'(m_valid), 1);
      cyc = 0;
      if (inject) begin
        send(inj);
        cyc = 1;
      end
      while (exp_q.size() != 0 && cyc < 2000) begin
        idle(1);
        cyc++;
      end
      check_eq("drained", exp_q.size(), 0);
      if (rdy_mode == 0) check_eq("throughput", cyc, n_out);
    end
    idle(tail + 2);
    check_eq("frame_err", fe_cnt - fe0, exp_err);
    check_eq("overflow", ov_cnt - ov0, (good && inject) ? 1 : 0);
    check_eq("busy_after", 32'(busy), 0);
  endtask

  task automatic rand_attempt();
    logic [15:0] w[$];
    int unsigned g[$];
    int unsigned len, p, tail, sync_at, cut;
    logic [15:0] s, v, inj;
    bit inject;
    repeat ($urandom_range(0, 2)) begin
      v = 16'($urandom);
      if (v == SYNC) v = ~v;
      w.push_back(v);
    end
    sync_at = w.size();
    w.push_back(SYNC);
    p = $urandom_range(0, 9);
    if (p == 0) begin
      len = $urandom_range(0, 1) ? 0 : $urandom_range(MAXL + 1, 65535);
      w.push_back(16'(len));
    end else begin
      len = $urandom_range(1, MAXL);
      w.push_back(16'(len));
      s = '0;
      repeat (len) begin
        v = 16'($urandom);
        s = s + v;
        w.push_back(v);
      end
      if (p == 1) s = s ^ 16'(1 << $urandom_range(0, 15));
      w.push_back(s);
    end
    foreach (w[k]) begin
      p = $urandom_range(0, 39);
      g.push_back(p == 0 ? TMO - 1 : p == 1 ? TMO + $urandom_range(0, 3) : $urandom_range(0, 2));
    end
    // a stall inside the frame ends the attempt there
    tail = 2;
    cut = 0;
    for (int unsigned k = sync_at + 1; k < w.size(); k++)
      if (cut == 0 && g[k] >= TMO) cut = k;
    if (cut != 0) begin
      tail = g[cut];
      while (w.size() > cut) begin
        void'(w.pop_back());
        void'(g.pop_back());
      end
    end
    inject = 1'($urandom_range(0, 1));
    inj = $urandom_range(0, 1) ? SYNC : 16'($urandom);
    rdy_mode = $urandom_range(0, 2);
    run_attempt(w, g, tail, inject, inj);
  endtask

  initial begin
    logic [15:0] w[$];
    int unsigned g[$];
    int unsigned nog[$];
    int unsigned fe0;

    idle(3);
    check_eq("rst_m_valid", 32'(m_valid), 0);
    check_eq("rst_m_last", 32'(m_last), 0);
    check_eq("rst_m_data", 32'(m_data), 0);
    check_eq("rst_frame_err", 32'(frame_err), 0);
    check_eq("rst_overflow", 32'(overflow), 0);
    check_eq("rst_busy", 32'(busy), 0);
    rstn = 1'b1;
    idle(2);

    rdy_mode = 0;
    w = '{SYNC, 16'h0003, 16'h0001, 16'h0002, 16'h0003, 16'h0006};
    run_attempt(w, nog, 2, 1'b0, 16'h0000);

    w = '{SYNC, 16'h0002, 16'hFFFF, 16'h0002, 16'h0001};
    run_attempt(w, nog, 2, 1'b0, 16'h0000);
    w = '{SYNC, 16'h0002, 16'hFFFF, 16'h0002, 16'h0002};
    run_attempt(w, nog, 2, 1'b0, 16'h0000);

    w = '{SYNC, 16'h0000};
    run_attempt(w, nog, 2, 1'b0, 16'h0000);
    w = '{SYNC, 16'h0011};
    run_attempt(w, nog, 2, 1'b0, 16'h0000);
    w = '{SYNC, 16'h0001, 16'h00AB, 16'h00AB};
    run_attempt(w, nog, 2, 1'b0, 16'h0000);
    w = '{SYNC, 16'h0010, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006,
          16'h0007, 16'h0008, 16'h0009, 16'h000A, 16'h000B, 16'h000C, 16'h000D,
          16'h000E, 16'h000F, 16'h0010, 16'h0088};
    run_attempt(w, nog, 2, 1'b0, 16'h0000);

    rdy_mode = 2;
    rdy_phase = 0;
    w = '{SYNC, 16'h0005, 16'h000A, 16'h0014, 16'h001E, 16'h0028, 16'h0032, 16'h0096};
    run_attempt(w, nog, 2, 1'b1, 16'h1234);
    rdy_mode = 0;

    w = '{SYNC, 16'h0002, 16'h0007};
    run_attempt(w, nog, TMO, 1'b0, 16'h0000);
    w = '{SYNC, 16'h0002, 16'h0007, 16'h0008, 16'h000F};
    g = '{0, 0, 0, TMO - 1, 0};
    run_attempt(w, g, 2, 1'b0, 16'h0000);
    g = '{0, 0, 0, TMO, 0};
    run_attempt(w, g, 2, 1'b0, 16'h0000);

    w = '{16'h0000, 16'h1111, SYNC, 16'h0001, 16'h0005, 16'h0005};
    run_attempt(w, nog, 2, 1'b0, 16'h0000);

    fe0 = fe_cnt;
    send(SYNC);
    send(16'h0004);
    send(16'h0001);
    send(16'h0002);
    check_eq("busy_mid", 32'(busy), 1);
    #2;
    rstn = 1'b0;
    #1;
    check_eq("mid_rst_m_valid", 32'(m_valid), 0);
    check_eq("mid_rst_m_last", 32'(m_last), 0);
    check_eq("mid_rst_m_data", 32'(m_data), 0);
    check_eq("mid_rst_frame_err", 32'(frame_err), 0);
    check_eq("mid_rst_overflow", 32'(overflow), 0);
    check_eq("mid_rst_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(3);
    check_eq("mid_rst_no_err", fe_cnt - fe0, 0);
    w = '{SYNC, 16'h0002, 16'h0010, 16'h0020, 16'h0030};
    run_attempt(w, nog, 2, 1'b0, 16'h0000);

    repeat (60) rand_attempt();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
